// File: rtl/ged_serial_ingress.sv
// Serial-pin ingress: synchronizes sclk/sdata/cs_n, deserializes MSB-first bytes
// and queues them in a small FIFO with ready/valid drain and a sticky overflow flag.
module ged_serial_ingress #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic       clr,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] fifo_level,
    output logic       overflow
);

    localparam int unsigned IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
    logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [7:0]             mem_d [FIFO_DEPTH];
    logic                   overflow_q, overflow_d;

    logic                   sclk_s, sdata_s, csn_s;
    logic                   byte_done;
    logic [7:0]             new_byte;
    logic [PTR_W-1:0]       level;
    logic                   full, empty, pop, push, drop;

    // Pins [7:3] carry nothing for this block
    logic unused_pins;
    assign unused_pins = ^ui_in[7:3];

    // Synchronizer shift chains and sclk edge-detect delay
    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], ui_in[0]};
        sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], ui_in[1]};
        csn_sync_d   = {csn_sync_q[SYNC_STAGES-2:0], ui_in[2]};
        sclk_s       = sclk_sync_q[SYNC_STAGES-1];
        sdata_s      = sdata_sync_q[SYNC_STAGES-1];
        csn_s        = csn_sync_q[SYNC_STAGES-1];
        sclk_dly_d   = sclk_s;
    end

    // Deserializer: accept a bit per qualified sclk rise, abort partial byte on deselect/disable
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        byte_done = 1'b0;
        new_byte  = {shift_q[6:0], sdata_s};
        if (csn_s || !ena) begin
            bit_cnt_d = 3'd0;
        end else if (sclk_s && !sclk_dly_q) begin
            shift_d = new_byte;
            if (bit_cnt_q == 3'd7) begin
                byte_done = 1'b1;
                bit_cnt_d = 3'd0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end
    end

    // FIFO bookkeeping: a pop in the same cycle frees the slot a full-FIFO write needs
    always_comb begin
        level      = wr_ptr_q - rd_ptr_q;
        full       = (level == PTR_W'(FIFO_DEPTH));
        empty      = (level == '0);
        pop        = !empty && out_ready;
        push       = byte_done && (!full || pop);
        drop       = byte_done && full && !pop;
        mem_d      = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = new_byte;
        end
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr) begin
            overflow_d = 1'b0;
        end
    end

    // State registers; reset discards everything including stored bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            csn_sync_q   <= '1;
            sclk_dly_q   <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_q        <= '{default: '0};
            overflow_q   <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            sdata_sync_q <= sdata_sync_d;
            csn_sync_q   <= csn_sync_d;
            sclk_dly_q   <= sclk_dly_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_q        <= mem_d;
            overflow_q   <= overflow_d;
        end
    end

    // Outputs derived directly from pointer/storage state
    assign out_valid  = !empty;
    assign fifo_level = 4'(level);
    assign out_data   = empty ? 8'h00 : mem_q[rd_ptr_q[IDX_W-1:0]];
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ged_serial_ingress.sv
// Scoreboard bench for ged_serial_ingress: directed serial bytes, popped bytes
// compared in order against an expected-byte queue.
module tb_ged_serial_ingress;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       clr;
    logic       out_ready;
    logic       sclk, sdata, cs_n;
    logic [7:0] ui_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic [3:0] fifo_level;
    logic       overflow;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q [$];

    assign ui_in = {5'b00000, cs_n, sdata, sclk};

    ged_serial_ingress #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .ui_in      (ui_in),
        .clr        (clr),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%02h expected=%02h", name, act, exp);
        end
    endtask

    // Advance n rising edges, landing 2ns after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        sdata = b;
        sclk  = 1'b0;
        tick(4);
        sclk  = 1'b1;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    // Sends bits 7..1 of v and leaves sclk low with bit 0 on sdata
    task automatic send_seven(input logic [7:0] v);
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        sdata = v[0];
        sclk  = 1'b0;
        tick(4);
    endtask

    // Monitor: every accepted pop must match the next expected byte
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pop_unexpected got=%02h expected=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        failures++;
                        $display("FAIL pop_data got=%02h expected=%02h", out_data, e);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; clr = 1'b0; out_ready = 1'b0;
        sclk = 1'b0; sdata = 1'b0; cs_n = 1'b1;
        tick(3);
        chk("rst_valid", 8'(out_valid), 8'h00);
        chk("rst_level", 8'(fifo_level), 8'h00);
        chk("rst_ovf", 8'(overflow), 8'h00);
        chk("rst_data", out_data, 8'h00);
        rst_n = 1'b1;
        cs_n  = 1'b0;
        tick(4);

        // Single byte 0xA5 with latency check on the final bit
        send_seven(8'hA5);
        sclk = 1'b1;
        tick(2);
        chk("lat_valid_e2", 8'(out_valid), 8'h00);
        tick(1);
        chk("lat_valid_e3", 8'(out_valid), 8'h01);
        chk("a5_data", out_data, 8'hA5);
        chk("a5_level", 8'(fifo_level), 8'h01);
        tick(1);
        exp_q.push_back(8'hA5);
        out_ready = 1'b1;
        tick(3);
        out_ready = 1'b0;
        chk("a5_drained", 8'(out_valid), 8'h00);

        // Overflow: five bytes into a four-deep FIFO
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        tick(2);
        chk("ovf_level", 8'(fifo_level), 8'h04);
        chk("ovf_flag", 8'(overflow), 8'h01);
        chk("ovf_head", out_data, 8'h01);
        out_ready = 1'b1;
        tick(8);
        out_ready = 1'b0;
        chk("ovf_drain_level", 8'(fifo_level), 8'h00);
        chk("ovf_sticky", 8'(overflow), 8'h01);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("ovf_clr", 8'(overflow), 8'h00);

        // Full FIFO with a pop coinciding with the write of the fifth byte
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h11 + 8'(i));
        exp_q.push_back(8'h05);
        chk("full_level", 8'(fifo_level), 8'h04);
        send_seven(8'h05);
        sclk = 1'b1;
        tick(2);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("simul_level", 8'(fifo_level), 8'h04);
        chk("simul_ovf", 8'(overflow), 8'h00);
        chk("simul_head", out_data, 8'h12);
        tick(2);
        out_ready = 1'b1;
        tick(8);
        out_ready = 1'b0;
        chk("simul_drained", 8'(fifo_level), 8'h00);

        // Partial byte aborted by cs_n, then a clean 0x3C
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        sclk = 1'b0;
        cs_n = 1'b1;
        tick(6);
        cs_n = 1'b0;
        tick(4);
        send_byte(8'h3C);
        exp_q.push_back(8'h3C);
        tick(1);
        chk("abort_level", 8'(fifo_level), 8'h01);
        chk("abort_data", out_data, 8'h3C);
        out_ready = 1'b1;
        tick(3);
        out_ready = 1'b0;

        // ena low blocks capture
        ena = 1'b0;
        send_byte(8'hFF);
        tick(2);
        chk("ena_level", 8'(fifo_level), 8'h00);
        ena = 1'b1;
        sclk = 1'b0;
        tick(4);

        // Reset with three stored bytes
        send_byte(8'h21);
        send_byte(8'h22);
        send_byte(8'h23);
        sclk = 1'b0;
        tick(2);
        chk("pre_rst_level", 8'(fifo_level), 8'h03);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 8'(fifo_level), 8'h00);
        chk("mid_rst_valid", 8'(out_valid), 8'h00);
        chk("mid_rst_data", out_data, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        send_byte(8'h5A);
        exp_q.push_back(8'h5A);
        tick(1);
        chk("post_rst_level", 8'(fifo_level), 8'h01);
        out_ready = 1'b1;
        tick(3);
        out_ready = 1'b0;
        tick(2);

        chk("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
